inst_issue_queue: RTL



---
 rtl/inst_issue_queue_pkg.sv | 58 +++++
 rtl/inst_issue_queue_decode_slot.sv | 132 +++++++++++++
 rtl/inst_issue_queue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/inst_issue_queue_pkg.sv
// Shared types for the instruction issue queue: decoded instruction format,
// queue entry layout and the serialising-instruction predicate.
package inst_issue_queue_pkg;

  typedef enum logic [3:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ, BR_J, BR_JR
  } br_op_e;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [3:0] {
    HL_NONE, HL_MULT, HL_MULTU, HL_DIV, HL_DIVU, HL_MFHI, HL_MFLO, HL_MTHI, HL_MTLO
  } hi_lo_op_e;

  typedef enum logic [1:0] {C0_NONE, C0_MFC0, C0_MTC0, C0_ERET} c0_op_e;
  typedef enum logic [1:0] {TLB_NONE, TLB_TLBR, TLB_TLBWI, TLB_TLBP} tlb_op_e;

  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;

  typedef struct packed {
    br_op_e    br_op;
    alu_op_e   alu_op;
    hi_lo_op_e hi_lo_op;
    c0_op_e    c0_op;
    tlb_op_e   tlb_op;
    mem_op_e   mem_op;
    logic      syscall;
    logic      brk;
    logic      invalid;
    logic      link;
    logic      rf_we;
    logic      use_imm;
    logic      sign_ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] jidx;
  } decoded_inst_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        excp;
  } queue_entry_t;

  function automatic logic is_serialising(decoded_inst_t d);
    return (d.c0_op != C0_NONE) || (d.tlb_op != TLB_NONE) ||
           d.syscall || d.brk || d.invalid;
  endfunction

endpackage

// File: rtl/inst_issue_queue_decode_slot.sv
// Combinational decode of one queue entry into decoded_inst_t, plus the
// pass-through PC/exception flag and the combined serialising indication.
module decode_slot
  import inst_issue_queue_pkg::*;
(
  input  queue_entry_t  entry,
  output decoded_inst_t inst,
  output logic [31:0]   pc,
  output logic          excp,
  output logic          serial
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [1:0] wsel;

  assign op    = entry.inst[31:26];
  assign rs    = entry.inst[25:21];
  assign rt    = entry.inst[20:16];
  assign rd    = entry.inst[15:11];
  assign funct = entry.inst[5:0];

  always_comb begin
    inst      = '0;
    wsel      = 2'd0;
    inst.rs   = rs;
    inst.rt   = rt;
    inst.sa   = entry.inst[10:6];
    inst.imm  = entry.inst[15:0];
    inst.jidx = entry.inst[25:0];
    // wsel: 0 no write, 1 rd, 2 rt, 3 $31
    case (op)
      6'h00: begin
        case (funct)
          6'h00: begin inst.alu_op = ALU_SLL;  wsel = 2'd1; end
          6'h02: begin inst.alu_op = ALU_SRL;  wsel = 2'd1; end
          6'h03: begin inst.alu_op = ALU_SRA;  wsel = 2'd1; end
          6'h08: inst.br_op = BR_JR;
          6'h09: begin inst.br_op = BR_JR; inst.link = 1'b1; wsel = 2'd1; end
          6'h0C: inst.syscall = 1'b1;
          6'h0D: inst.brk = 1'b1;
          6'h10: begin inst.hi_lo_op = HL_MFHI; wsel = 2'd1; end
          6'h11: inst.hi_lo_op = HL_MTHI;
          6'h12: begin inst.hi_lo_op = HL_MFLO; wsel = 2'd1; end
          6'h13: inst.hi_lo_op = HL_MTLO;
          6'h18: inst.hi_lo_op = HL_MULT;
          6'h19: inst.hi_lo_op = HL_MULTU;
          6'h1A: inst.hi_lo_op = HL_DIV;
          6'h1B: inst.hi_lo_op = HL_DIVU;
          6'h21: begin inst.alu_op = ALU_ADD;  wsel = 2'd1; end
          6'h23: begin inst.alu_op = ALU_SUB;  wsel = 2'd1; end
          6'h24: begin inst.alu_op = ALU_AND;  wsel = 2'd1; end
          6'h25: begin inst.alu_op = ALU_OR;   wsel = 2'd1; end
          6'h26: begin inst.alu_op = ALU_XOR;  wsel = 2'd1; end
          6'h27: begin inst.alu_op = ALU_NOR;  wsel = 2'd1; end
          6'h2A: begin inst.alu_op = ALU_SLT;  wsel = 2'd1; end
          6'h2B: begin inst.alu_op = ALU_SLTU; wsel = 2'd1; end
          default: inst.invalid = 1'b1;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00: inst.br_op = BR_BLTZ;
          5'h01: inst.br_op = BR_BGEZ;
          5'h10: begin inst.br_op = BR_BLTZ; inst.link = 1'b1; wsel = 2'd3; end
          5'h11: begin inst.br_op = BR_BGEZ; inst.link = 1'b1; wsel = 2'd3; end
          default: inst.invalid = 1'b1;
        endcase
      end
      6'h02: inst.br_op = BR_J;
      6'h03: begin inst.br_op = BR_J; inst.link = 1'b1; wsel = 2'd3; end
      6'h04: inst.br_op = BR_BEQ;
      6'h05: inst.br_op = BR_BNE;
      6'h06: inst.br_op = BR_BLEZ;
      6'h07: inst.br_op = BR_BGTZ;
      6'h09: begin inst.alu_op = ALU_ADD;  inst.use_imm = 1'b1; inst.sign_ext = 1'b1; wsel = 2'd2; end
      6'h0A: begin inst.alu_op = ALU_SLT;  inst.use_imm = 1'b1; inst.sign_ext = 1'b1; wsel = 2'd2; end
      6'h0B: begin inst.alu_op = ALU_SLTU; inst.use_imm = 1'b1; inst.sign_ext = 1'b1; wsel = 2'd2; end
      6'h0C: begin inst.alu_op = ALU_AND;  inst.use_imm = 1'b1; wsel = 2'd2; end
      6'h0D: begin inst.alu_op = ALU_OR;   inst.use_imm = 1'b1; wsel = 2'd2; end
      6'h0E: begin inst.alu_op = ALU_XOR;  inst.use_imm = 1'b1; wsel = 2'd2; end
      6'h0F: begin inst.alu_op = ALU_LUI;  inst.use_imm = 1'b1; wsel = 2'd2; end
      6'h10: begin
        if (rs == 5'h00) begin
          inst.c0_op = C0_MFC0;
          wsel = 2'd2;
        end else if (rs == 5'h04) begin
          inst.c0_op = C0_MTC0;
        end else if (rs[4]) begin
          case (funct)
            6'h01:   inst.tlb_op = TLB_TLBR;
            6'h02:   inst.tlb_op = TLB_TLBWI;
            6'h08:   inst.tlb_op = TLB_TLBP;
            6'h18:   inst.c0_op  = C0_ERET;
            default: inst.invalid = 1'b1;
          endcase
        end else begin
          inst.invalid = 1'b1;
        end
      end
      6'h20: begin inst.mem_op = MEM_LB;  wsel = 2'd2; end
      6'h21: begin inst.mem_op = MEM_LH;  wsel = 2'd2; end
      6'h23: begin inst.mem_op = MEM_LW;  wsel = 2'd2; end
      6'h24: begin inst.mem_op = MEM_LBU; wsel = 2'd2; end
      6'h25: begin inst.mem_op = MEM_LHU; wsel = 2'd2; end
      6'h28: inst.mem_op = MEM_SB;
      6'h29: inst.mem_op = MEM_SH;
      6'h2B: inst.mem_op = MEM_SW;
      default: inst.invalid = 1'b1;
    endcase
    if (inst.mem_op != MEM_NONE) begin
      inst.alu_op   = ALU_ADD;
      inst.use_imm  = 1'b1;
      inst.sign_ext = 1'b1;
    end
    inst.rf_we = (wsel != 2'd0);
    case (wsel)
      2'd1:    inst.dest = rd;
      2'd2:    inst.dest = rt;
      2'd3:    inst.dest = 5'd31;
      default: inst.dest = 5'd0;
    endcase
  end

  assign pc     = entry.pc;
  assign excp   = entry.excp;
  assign serial = is_serialising(inst) || entry.excp;

endmodule

// File: rtl/inst_issue_queue.sv
// Circular instruction queue between fetch and register read; decodes the
// oldest ISSUE_WIDTH entries and issues an in-order group each cycle.
module inst_issue_queue
  import inst_issue_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               flush,
  input  logic                               fetch_valid,
  input  logic [FETCH_WIDTH-1:0]             fetch_mask,
  input  logic [FETCH_WIDTH-1:0][31:0]       fetch_inst,
  input  logic [FETCH_WIDTH-1:0][31:0]       fetch_pc,
  input  logic [FETCH_WIDTH-1:0]             fetch_excp,
  output logic                               fetch_ready,
  output logic [ISSUE_WIDTH-1:0]             issue_valid,
  output decoded_inst_t [ISSUE_WIDTH-1:0]    issue_inst,
  output logic [ISSUE_WIDTH-1:0][31:0]       issue_pc,
  output logic [ISSUE_WIDTH-1:0]             issue_excp,
  output logic [ISSUE_WIDTH-1:0]             issue_is_ds,
  input  logic                               issue_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  queue_entry_t            mem [DEPTH];
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [CW-1:0]           count;
  logic                    hold;
  logic [ISSUE_WIDTH-1:0]  hold_valid;

  decoded_inst_t           dec       [ISSUE_WIDTH];
  logic [31:0]             slot_pc   [ISSUE_WIDTH];
  logic                    slot_excp [ISSUE_WIDTH];
  logic                    slot_ser  [ISSUE_WIDTH];

  logic [ISSUE_WIDTH-1:0]  grp;
  logic                    stop;
  logic                    hl_used;
  logic                    blk;
  logic                    prev_br;
  logic                    nxt;
  logic                    push_en;
  logic [CW-1:0]           n_push;
  logic [CW-1:0]           n_pop;

  assign fetch_ready = (CW'(DEPTH) - count) >= CW'(FETCH_WIDTH);
  assign push_en     = fetch_valid && fetch_ready && !flush;

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slot
    logic [PW-1:0] idx;
    assign idx = head + PW'(k);
    decode_slot u_decode_slot (
      .entry  (mem[idx]),
      .inst   (dec[k]),
      .pc     (slot_pc[k]),
      .excp   (slot_excp[k]),
      .serial (slot_ser[k])
    );
    // Storage is not reset, so anything beyond the occupied entries reads as zero
    assign issue_inst[k] = (count > CW'(k)) ? dec[k]       : '0;
    assign issue_pc[k]   = (count > CW'(k)) ? slot_pc[k]   : '0;
    assign issue_excp[k] = (count > CW'(k)) ? slot_excp[k] : 1'b0;
  end

  always_comb begin
    grp     = '0;
    stop    = 1'b0;
    hl_used = 1'b0;
    blk     = 1'b0;
    prev_br = 1'b0;
    nxt     = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      blk = stop || (int'(count) <= k);
      if (dec[k].br_op != BR_NONE && (k >= ISSUE_WIDTH - 1 || int'(count) <= k + 1))
        blk = 1'b1;
      if (slot_ser[k] && k != 0 && !prev_br)
        blk = 1'b1;
      if (dec[k].hi_lo_op != HL_NONE && hl_used)
        blk = 1'b1;
      // The delay slot of a linking branch gets the link value via the PC+8 bypass
      for (int j = 0; j < k; j++) begin
        if (grp[j] && dec[j].rf_we && dec[j].dest != 5'd0 &&
            (dec[k].rs == dec[j].dest || dec[k].rt == dec[j].dest) &&
            !(j == k - 1 && dec[j].br_op != BR_NONE && dec[j].link))
          blk = 1'b1;
      end
      if (blk) begin
        stop = 1'b1;
      end else begin
        grp[k] = 1'b1;
        if (dec[k].hi_lo_op != HL_NONE) hl_used = 1'b1;
        if (slot_ser[k]) stop = 1'b1;
      end
      prev_br = !blk && (dec[k].br_op != BR_NONE);
    end
    // A branch cannot issue without its delay slot in the same group
    for (int k = ISSUE_WIDTH - 1; k >= 0; k--) begin
      if (grp[k] && dec[k].br_op != BR_NONE && !nxt) grp[k] = 1'b0;
      nxt = grp[k];
    end
  end

  always_comb begin
    issue_valid = hold ? hold_valid : grp;
    if (flush) issue_valid = '0;
    issue_is_ds = '0;
    for (int k = 1; k < ISSUE_WIDTH; k++)
      issue_is_ds[k] = issue_valid[k-1] && (dec[k-1].br_op != BR_NONE);
  end

  always_comb begin
    n_push = '0;
    n_pop  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (push_en && fetch_mask[i]) n_push = n_push + CW'(1);
    for (int k = 0; k < ISSUE_WIDTH; k++)
      if (issue_ready && issue_valid[k]) n_pop = n_pop + CW'(1);
  end

  // A stalled group is frozen so arriving entries cannot widen it under the consumer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      hold       <= 1'b0;
      hold_valid <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      hold       <= 1'b0;
      hold_valid <= '0;
    end else begin
      head       <= head + n_pop[PW-1:0];
      tail       <= tail + n_push[PW-1:0];
      count      <= count + n_push - n_pop;
      hold       <= (issue_valid != '0) && !issue_ready;
      hold_valid <= issue_valid;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (push_en && fetch_mask[i])
        mem[tail + PW'(i)] <= '{inst: fetch_inst[i], pc: fetch_pc[i], excp: fetch_excp[i]};
  end

endmodule
